// File: rtl/ps2_pkg.sv
// ps2_pkg
//   Shared types and constants for the PS/2 Set-2 scan code decoder.
//   - ps2_prefix_state_t : prefix-tracking FSM state
//   - PS2_* byte constants : prefix bytes and controller housekeeping bytes
//   - ps2_key_event_t : one decoded key event, {extended, released, code}
//   - is_housekeeping() : true for bytes the controller emits on its own
//     (BAT result, ACK, resend, error codes) rather than key codes
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_prefix_state_t;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  typedef struct packed {
    logic       extended;
    logic       released;
    logic [7:0] code;
  } ps2_key_event_t;

  function automatic logic is_housekeeping(input logic [7:0] b);
    return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_RESEND) ||
           (b == PS2_ERR0)   || (b == PS2_ERR1);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo
//   First-word fall-through FIFO of ps2_key_event_t.
//   Ports:
//     clk, reset  : clock, asynchronous active-high reset
//     push        : write push_data this cycle (ignored when full unless a
//                   pop happens in the same cycle)
//     push_data   : event to write
//     pop         : consume the head entry (ignored when empty)
//     pop_data    : head entry; reads as all zeros while empty
//     full, empty : occupancy flags
//     count       : number of occupied entries
//   Handshake: the head is offered whenever empty=0; it is consumed on a
//   clock edge where pop=1 and empty=0.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  ps2_key_event_t             push_data,
  input  logic                       pop,
  output ps2_key_event_t             pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ps2_key_event_t mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           push_ok;
  logic           pop_ok;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Zeroed while empty so the head reads as a clean value after reset.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers are AW bits wide and DEPTH is a power of two, so they wrap
  // naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
//   Collapses PS/2 Set-2 byte sequences (E0 / F0 prefixes) into single key
//   events and queues them in a FWFT FIFO for the consumer.
//   Ports:
//     clk, reset    : clock, asynchronous active-high reset
//     scan_code     : received byte, valid with scan_valid
//     scan_valid    : one-cycle pulse, good frame
//     scan_error    : one-cycle pulse, bad frame (wins over scan_valid)
//     key_code      : code of the head event
//     key_extended  : head event was preceded by E0
//     key_released  : head event was preceded by F0
//     key_valid     : FIFO non-empty
//     key_ready     : consumer accepts the head event
//     overflow      : sticky, an event was dropped on a full FIFO
//     overflow_clr  : clears overflow, wins over a same-cycle set
//     fifo_count    : occupied FIFO entries
//     dbg_state     : current prefix FSM state
//   Handshake: an event is transferred on a clock edge where key_valid=1 and
//   key_ready=1; key_* are stable while key_valid=1 and key_ready=0.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int PREFIX_TIMEOUT = 100000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    scan_code,
  input  logic                          scan_valid,
  input  logic                          scan_error,
  output logic [7:0]                    key_code,
  output logic                          key_extended,
  output logic                          key_released,
  output logic                          key_valid,
  input  logic                          key_ready,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output ps2_prefix_state_t             dbg_state
);

  localparam int TW = $clog2(PREFIX_TIMEOUT);

  ps2_prefix_state_t state;
  logic [TW-1:0]     tmo_cnt;
  logic              good_byte;
  logic              push;
  logic              drop;
  ps2_key_event_t    new_event;
  ps2_key_event_t    head;
  logic              fifo_full;
  logic              fifo_empty;

  assign dbg_state = state;

  // A bad frame masks any simultaneous good-frame pulse.
  assign good_byte = scan_valid & ~scan_error;

  always_comb begin
    new_event          = '0;
    new_event.code     = scan_code;
    new_event.extended = (state == ST_EXT) || (state == ST_EXT_BRK);
    new_event.released = (state == ST_BRK) || (state == ST_EXT_BRK);
  end

  // Housekeeping bytes are only filtered when no prefix is pending; after a
  // prefix they are legitimate key codes (e.g. F0 AA is the break of 0xAA).
  assign push = good_byte && (scan_code != PS2_EXT) && (scan_code != PS2_BRK) &&
                !((state == ST_IDLE) && is_housekeeping(scan_code));

  // Full implies non-empty, so key_ready alone tells whether the head leaves.
  assign drop = push & fifo_full & ~key_ready;

  // Prefix FSM and stall timeout. A byte arriving on the same edge that the
  // timeout would expire takes precedence, since it restarts the sequence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      tmo_cnt <= '0;
    end else if (scan_error) begin
      state   <= ST_IDLE;
      tmo_cnt <= '0;
    end else if (scan_valid) begin
      tmo_cnt <= '0;
      if (scan_code == PS2_EXT) begin
        state <= ST_EXT;
      end else if (scan_code == PS2_BRK) begin
        case (state)
          ST_IDLE: state <= ST_BRK;
          ST_EXT:  state <= ST_EXT_BRK;
          default: state <= state;
        endcase
      end else begin
        state <= ST_IDLE;
      end
    end else if (state != ST_IDLE) begin
      if (tmo_cnt == TW'(PREFIX_TIMEOUT - 1)) begin
        state   <= ST_IDLE;
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             overflow <= 1'b0;
    else if (overflow_clr) overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (new_event),
    .pop       (key_ready),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign key_valid    = ~fifo_empty;
  assign key_code     = head.code;
  assign key_extended = head.extended;
  assign key_released = head.released;

endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Consumes completed bytes from the PS/2 receive state controller and shift register, and collapses multi-byte Set-2 scan code sequences (E0 / F0 prefixes) into single key events. It buffers those events in a small FIFO that presents a ready/valid interface to the keyboard consumer (CPU I/O register or game logic). Controller housekeeping bytes are filtered out. A stalled prefix sequence is abandoned after a timeout.

## Interface
- FIFO_DEPTH, 8, event FIFO entries; power of two, ≥2
- PREFIX_TIMEOUT, 100000, cycles a prefix may wait for its next byte before being abandoned; ≥2
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- scan_code  in  8  received byte, stable while scan_valid is high
- scan_valid  in  1  one-cycle pulse: frame complete, parity good
- scan_error  in  1  one-cycle pulse: frame complete, parity or stop bit bad
- key_code  out  8  final (non-prefix) scan code of the head event
- key_extended  out  1  head event was preceded by E0
- key_released  out  1  head event was preceded by F0 (break)
- key_valid  out  1  FIFO non-empty
- key_ready  in  1  consumer accepts the head event
- overflow  out  1  sticky: an event was dropped because the FIFO was full
- overflow_clr  in  1  clears overflow; takes priority over a same-cycle set
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries

## Operation
- Prefix FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 then F0 seen).
- scan_valid with 0xE0: IDLE→EXT. Any other state→EXT, discarding the earlier prefix.
- scan_valid with 0xF0: IDLE→BRK, EXT→EXT_BRK. BRK and EXT_BRK remain in place.
- scan_valid with any other byte: push {code, extended, released} per the current state, then →IDLE.
  - In IDLE only, bytes 0x00, 0xAA, 0xFA, 0xFE, 0xFF are discarded with no push.
  - In prefix states these bytes are pushed as ordinary codes.
- scan_error in any state: →IDLE, no push, byte ignored.
- scan_valid and scan_error both high: treated as scan_error.
- Timeout counter:
  - Cleared on every scan_valid or scan_error.
  - Counts while FSM ≠ IDLE.
  - At count == PREFIX_TIMEOUT−1: →IDLE, no push.
- FIFO is first-word fall-through. key_* outputs show the head entry whenever key_valid=1 and are don't-care otherwise.
- Pop occurs on key_valid & key_ready.
- Push when full with no same-cycle pop: event dropped, overflow←1.
- Push and pop in the same cycle when full: both succeed; count unchanged; no overflow.
- Push and pop in the same cycle when empty: push succeeds; pop is ignored because key_valid=0.
- Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: FSM=IDLE, timeout=0, FIFO empty, key_valid=0, fifo_count=0, overflow=0, key_code/key_extended/key_released=0.
- Reset mid-sequence discards partial prefixes and all buffered events.
- Latency: scan_valid of a final byte at edge N → entry written at N. With the FIFO previously empty, key_valid=1 and key_* valid after edge N, i.e. one cycle.
- fifo_count updates on the same edge as push/pop.
- overflow rises on the edge of the dropped push.
- No combinational path from scan_* to key_*.
- key_ready→key_valid is registered: key_valid deasserts the cycle after the last pop.

## Structure
- Shared package ps2_pkg holds:
  - prefix state enum
  - byte constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_BAT_OK=8'hAA, PS2_ACK=8'hFA, PS2_RESEND=8'hFE, PS2_ERR0=8'h00, PS2_ERR1=8'hFF
  - packed struct ps2_key_event_t {extended, released, code[7:0]} (10 bits)
- Sub-module ps2_event_fifo: generic FWFT FIFO of ps2_key_event_t, with full/empty/count.
- The decoder FSM and timeout counter live in the top module.

## Test plan
- Bytes 0x1C → key_valid=1 one cycle later with code=0x1C, ext=0, rel=0. Bytes F0,1C → a second event code=0x1C, rel=1; key_ready=1 drains both, in order.
- Bytes E0,F0,75 → exactly one event: code=0x75, ext=1, rel=1. fifo_count=1 throughout until popped.
- Bytes AA,FA,FE in IDLE → no events, fifo_count=0. Bytes F0,AA → event code=0xAA, rel=1.
- Byte E0, idle PREFIX_TIMEOUT cycles (parameter set to 16), then 0x1C → event code=0x1C, ext=0. E0 followed by scan_error, then 0x1C → ext=0.
- key_ready=0, push FIFO_DEPTH+1 events → fifo_count=FIFO_DEPTH, overflow=1, first FIFO_DEPTH events intact. Pulse overflow_clr → overflow=0. Full, then push with key_ready=1 in the same cycle → accepted, no overflow.
- reset asserted asynchronously between F0 and the code byte, with 3 events queued → all outputs at reset values immediately. After release, byte 0x1C → event rel=0.
